apb2axi_issue_sched: RTL

Outstanding-transaction scheduler in the ACLK domain, between the write/read request FIFOs and the write/read builders. Each command popped from a FIFO is admitted to its builder only while AXI credits are available: per-direction caps plus one shared total cap, with round-robin arbitration when both directions contend for the last shared credit. Credits are returned on write-response and read-last completions. It exposes outstanding counts, an idle flag and a sticky underflow error.

---
 rtl/apb2axi_pkg.sv | 23 ++
 rtl/apb2axi_credit_cnt.sv | 33 +++
 rtl/apb2axi_issue_sched.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/apb2axi_pkg.sv
// Shared definitions for the APB-to-AXI bridge.
package apb2axi_pkg;

   // Width of one command entry carried through the request FIFOs.
   localparam int unsigned CMD_ENTRY_W = 48;

   // Default outstanding-transaction limits for the issue scheduler.
   localparam int unsigned MAX_WR_OUT_DEF = 4;
   localparam int unsigned MAX_RD_OUT_DEF = 4;
   localparam int unsigned MAX_TOTAL_DEF  = 6;

   // Issue direction, also used as the round-robin pointer encoding.
   typedef enum logic {
      DIR_WR = 1'b0,
      DIR_RD = 1'b1
   } issue_dir_e;

   // Counter width able to hold the larger per-direction cap.
   function automatic int unsigned cnt_width(input int unsigned max_a, input int unsigned max_b);
      return $clog2(((max_a > max_b) ? max_a : max_b) + 1);
   endfunction

endpackage

// File: rtl/apb2axi_credit_cnt.sv
// Outstanding-transaction counter: +1 on load, -1 on completion, sticky underflow.
module apb2axi_credit_cnt #(
   parameter int unsigned MAX   = 4,
   parameter int unsigned CNT_W = 3
) (
   input  logic             aclk,
   input  logic             aresetn,
   input  logic             inc,
   input  logic             dec,
   output logic [CNT_W-1:0] cnt,
   output logic             underflow
);

   // Count update; a completion at zero holds the count and flags underflow.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         cnt       <= '0;
         underflow <= 1'b0;
      end else begin
         case ({inc, dec})
            2'b10: begin
               if (cnt != CNT_W'(MAX)) cnt <= cnt + CNT_W'(1);
            end
            2'b01: begin
               if (cnt == '0) underflow <= 1'b1;
               else           cnt       <= cnt - CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/apb2axi_issue_sched.sv
// Credit-gated issue scheduler between request FIFOs and AXI builders.
// Optional read-after-write fence: define APB2AXI_WR_FENCE_EN.
module apb2axi_issue_sched
   import apb2axi_pkg::*;
#(
   parameter  int unsigned ENTRY_W    = CMD_ENTRY_W,
   parameter  int unsigned MAX_WR_OUT = MAX_WR_OUT_DEF,
   parameter  int unsigned MAX_RD_OUT = MAX_RD_OUT_DEF,
   parameter  int unsigned MAX_TOTAL  = MAX_TOTAL_DEF,
   localparam int unsigned CNT_W      = cnt_width(MAX_WR_OUT, MAX_RD_OUT)
) (
   input  logic               aclk,
   input  logic               aresetn,
   input  logic               wr_fifo_vld,
   input  logic [ENTRY_W-1:0] wr_fifo_data,
   output logic               wr_fifo_rdy,
   output logic               wr_bld_vld,
   output logic [ENTRY_W-1:0] wr_bld_data,
   input  logic               wr_bld_rdy,
   input  logic               rd_fifo_vld,
   input  logic [ENTRY_W-1:0] rd_fifo_data,
   output logic               rd_fifo_rdy,
   output logic               rd_bld_vld,
   output logic [ENTRY_W-1:0] rd_bld_data,
   input  logic               rd_bld_rdy,
   input  logic               wr_cpl,
   input  logic               rd_cpl,
   output logic [CNT_W-1:0]   wr_out_cnt,
   output logic [CNT_W-1:0]   rd_out_cnt,
   output logic               idle,
   output logic               cpl_underflow
);

   localparam int unsigned TOT_W = CNT_W + 1;

   issue_dir_e       rr_ptr, rr_ptr_nxt;
   logic             wr_load, rd_load;
   logic             wr_space, rd_space;
   logic             wr_elig, rd_elig;
   logic             rd_fence_ok;
   logic             shared_ok, last_credit;
   logic [TOT_W-1:0] total_cnt;
   logic             wr_uf, rd_uf;

   // Output register can take a new entry when empty or emptying this cycle.
   assign wr_space = !wr_bld_vld || wr_bld_rdy;
   assign rd_space = !rd_bld_vld || rd_bld_rdy;

   assign total_cnt   = TOT_W'(wr_out_cnt) + TOT_W'(rd_out_cnt);
   assign shared_ok   = total_cnt <  TOT_W'(MAX_TOTAL);
   assign last_credit = total_cnt == TOT_W'(MAX_TOTAL - 1);

`ifdef APB2AXI_WR_FENCE_EN
   // Reads wait until every write has completed and none is queued.
   assign rd_fence_ok = (wr_out_cnt == '0) && !wr_bld_vld;
`else
   assign rd_fence_ok = 1'b1;
`endif

   assign wr_elig = aresetn && wr_space && wr_fifo_vld && (wr_out_cnt < CNT_W'(MAX_WR_OUT));
   assign rd_elig = aresetn && rd_space && rd_fifo_vld && (rd_out_cnt < CNT_W'(MAX_RD_OUT))
                    && rd_fence_ok;

   // Grant: round-robin only when both contend for the last shared credit.
   always_comb begin
      wr_load    = 1'b0;
      rd_load    = 1'b0;
      rr_ptr_nxt = rr_ptr;
      if (shared_ok) begin
         if (wr_elig && rd_elig && last_credit) begin
            if (rr_ptr == DIR_WR) begin
               wr_load    = 1'b1;
               rr_ptr_nxt = DIR_RD;
            end else begin
               rd_load    = 1'b1;
               rr_ptr_nxt = DIR_WR;
            end
         end else begin
            wr_load = wr_elig;
            rd_load = rd_elig;
         end
      end
   end

   assign wr_fifo_rdy = wr_load;
   assign rd_fifo_rdy = rd_load;

   // Round-robin pointer register.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) rr_ptr <= DIR_WR;
      else          rr_ptr <= rr_ptr_nxt;
   end

   // Write output register; data held while the builder stalls.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wr_bld_vld  <= 1'b0;
         wr_bld_data <= '0;
      end else if (wr_load) begin
         wr_bld_vld  <= 1'b1;
         wr_bld_data <= wr_fifo_data;
      end else if (wr_bld_rdy) begin
         wr_bld_vld  <= 1'b0;
      end
   end

   // Read output register; data held while the builder stalls.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         rd_bld_vld  <= 1'b0;
         rd_bld_data <= '0;
      end else if (rd_load) begin
         rd_bld_vld  <= 1'b1;
         rd_bld_data <= rd_fifo_data;
      end else if (rd_bld_rdy) begin
         rd_bld_vld  <= 1'b0;
      end
   end

   apb2axi_credit_cnt #(.MAX(MAX_WR_OUT), .CNT_W(CNT_W)) u_wr_cnt (
      .aclk      (aclk),
      .aresetn   (aresetn),
      .inc       (wr_load),
      .dec       (wr_cpl),
      .cnt       (wr_out_cnt),
      .underflow (wr_uf)
   );

   apb2axi_credit_cnt #(.MAX(MAX_RD_OUT), .CNT_W(CNT_W)) u_rd_cnt (
      .aclk      (aclk),
      .aresetn   (aresetn),
      .inc       (rd_load),
      .dec       (rd_cpl),
      .cnt       (rd_out_cnt),
      .underflow (rd_uf)
   );

   assign cpl_underflow = wr_uf || rd_uf;
   assign idle = (wr_out_cnt == '0) && (rd_out_cnt == '0) && !wr_bld_vld && !rd_bld_vld;

endmodule
